// File: rtl/probe_capture.sv
// Parametrised probe capture core: mask/value trigger, pre-trigger window, oldest-first readout.
// Optional build macro PROBE_CAPTURE_QUAL_EN enables the storage qualifier input (qual).
module probe_capture #(
    parameter int DATA_W   = 19,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] probe,
    input  logic              arm,
    input  logic              abort,
    input  logic [DATA_W-1:0] trig_value,
    input  logic [DATA_W-1:0] trig_mask,
    input  logic              trig_edge,
    input  logic              qual,
    output logic [2:0]        state,
    output logic              triggered,
    output logic              done,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_last
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int POST_LEN = DEPTH - PRE_TRIG - 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [CW-1:0] POST_LAST = CW'((POST_LEN > 0) ? POST_LEN - 1 : 0);
    localparam logic [CW-1:0] RD_TOTAL  = CW'(DEPTH);
    localparam logic [CW-1:0] RD_FINAL  = CW'(DEPTH - 1);
    localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_reg;
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW-1:0]     trig_addr_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     rd_cnt_reg;
    logic              match_d_reg;
    logic              triggered_reg;
    logic              done_reg;
    logic              rd_valid_reg;
    logic              rd_last_reg;
    logic [DATA_W-1:0] ram_q_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic match;
    logic adv;
    logic hit;
    logic capturing;
    logic wr_en;
    logic rd_accept;

`ifdef PROBE_CAPTURE_QUAL_EN
    assign adv = qual;
`else
    assign adv = 1'b1;
    logic unused_qual;
    assign unused_qual = qual;
`endif

    assign match     = ((probe ^ trig_value) & trig_mask) == '0;
    assign hit       = adv & match & (~trig_edge | ~match_d_reg);
    assign capturing = (state_reg == S_FILL) | (state_reg == S_WAIT) | (state_reg == S_POST);
    assign wr_en     = capturing & adv & ~abort;
    // Reads stop once the whole window has been issued; the final cycle only retires to IDLE.
    assign rd_accept = (state_reg == S_DONE) & rd_en & ~abort & ~rd_last_reg
                     & (rd_cnt_reg != RD_TOTAL);

    // Sample buffer: no reset so it maps onto block RAM with a registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= probe;
        end
        if (rd_accept) begin
            ram_q_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            trig_addr_reg <= '0;
            cnt_reg       <= '0;
            rd_cnt_reg    <= '0;
            match_d_reg   <= 1'b0;
            triggered_reg <= 1'b0;
            done_reg      <= 1'b0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
        end else begin
            if (adv) begin
                match_d_reg <= match;
            end
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end

            if (abort) begin
                state_reg     <= S_IDLE;
                triggered_reg <= 1'b0;
                done_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (arm) begin
                            wr_ptr_reg <= '0;
                            cnt_reg    <= '0;
                            rd_cnt_reg <= '0;
                            state_reg  <= (PRE_TRIG == 0) ? S_WAIT : S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (adv) begin
                            cnt_reg <= cnt_reg + CW'(1);
                            if (cnt_reg == PRE_LAST) begin
                                state_reg <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (hit) begin
                            trig_addr_reg <= wr_ptr_reg;
                            triggered_reg <= 1'b1;
                            cnt_reg       <= '0;
                            if (POST_LEN == 0) begin
                                state_reg  <= S_DONE;
                                done_reg   <= 1'b1;
                                rd_ptr_reg <= wr_ptr_reg - PRE_OFS;
                            end else begin
                                state_reg <= S_POST;
                            end
                        end
                    end
                    S_POST: begin
                        if (adv) begin
                            cnt_reg <= cnt_reg + CW'(1);
                            if (cnt_reg == POST_LAST) begin
                                state_reg  <= S_DONE;
                                done_reg   <= 1'b1;
                                rd_ptr_reg <= trig_addr_reg - PRE_OFS;
                            end
                        end
                    end
                    S_DONE: begin
                        if (rd_last_reg) begin
                            state_reg     <= S_IDLE;
                            triggered_reg <= 1'b0;
                            done_reg      <= 1'b0;
                        end else if (rd_accept) begin
                            rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                            rd_cnt_reg   <= rd_cnt_reg + CW'(1);
                            rd_valid_reg <= 1'b1;
                            rd_last_reg  <= (rd_cnt_reg == RD_FINAL);
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign state     = state_reg;
    assign triggered = triggered_reg;
    assign done      = done_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_last   = rd_last_reg;
    assign rd_data   = rd_valid_reg ? ram_q_reg : '0;

endmodule

// File: tb/tb_probe_capture.sv
// Bench for probe_capture: table of trigger set-ups with scoreboarded readout, plus abort/reset/PRE_TRIG=0 sequences.
module tb_probe_capture;

    localparam int DW    = 19;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] probe, trig_value, trig_mask;
    logic          arm, arm0, abort, trig_edge, qual, rd_en, rd_en0;
    logic [2:0]    state, state0;
    logic          triggered, triggered0, done, done0;
    logic          rd_valid, rd_valid0, rd_last, rd_last0;
    logic [DW-1:0] rd_data, rd_data0;

    always #5 clk = ~clk;

    probe_capture #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
        .clk(clk), .rst(rst), .probe(probe), .arm(arm), .abort(abort),
        .trig_value(trig_value), .trig_mask(trig_mask), .trig_edge(trig_edge), .qual(qual),
        .state(state), .triggered(triggered), .done(done),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
    );

    probe_capture #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(0)) dut0 (
        .clk(clk), .rst(rst), .probe(probe), .arm(arm0), .abort(abort),
        .trig_value(trig_value), .trig_mask(trig_mask), .trig_edge(trig_edge), .qual(qual),
        .state(state0), .triggered(triggered0), .done(done0),
        .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0), .rd_last(rd_last0)
    );

    typedef struct {
        logic [DW-1:0] exp_data;
        logic          exp_last;
    } rd_exp_t;

    typedef struct {
        logic          edge_m;
        logic [DW-1:0] mask;
        logic [DW-1:0] value;
        int            pmode;
        int            exp_k;
    } vec_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;
    vec_t    vecs[$];
    int      checks = 0;
    int      errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // pmode 1: bit0 high for k<4, low for k=4..6, high again from 7; upper bits carry k.
    function automatic logic [DW-1:0] pv(input int pmode, input int k);
        logic b;
        b = (k < 4 || k >= 7);
        if (pmode == 1) return DW'((k << 1) | int'(b));
        return DW'(k);
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", 32'(rd_data), 32'(mon_e.exp_data));
                check("rd_last", 32'(rd_last), 32'(mon_e.exp_last));
            end
        end else if (rst === 1'b1 && rd_last === 1'b1) begin
            check("rd_last_without_valid", 32'(rd_last), 32'd0);
        end
    end

    task automatic capture_phase(input vec_t v);
        int  k;
        int  seen;
        int  step;
        bit  got_done;
        step = (v.pmode == 2) ? 3 : 1;
        trig_edge  = v.edge_m;
        trig_mask  = v.mask;
        trig_value = v.value;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("state_fill", 32'(state), 32'd1);
        k = 0;
        seen = -1;
        got_done = 1'b0;
        for (int c = 0; c < 300 && !got_done; c++) begin
            probe = pv(v.pmode, k);
`ifdef PROBE_CAPTURE_QUAL_EN
            qual = (v.pmode == 2) ? (k % 3 == 0) : 1'b1;
`else
            qual = 1'($urandom_range(0, 1));
`endif
            tick();
            if (triggered && seen < 0) seen = k;
            if (done) got_done = 1'b1;
            else k++;
        end
        check("trig_sample", 32'(seen), 32'(v.exp_k));
        check("done_reached", 32'(got_done), 32'd1);
        check("done_sample", 32'(k), 32'(v.exp_k + step * (DEPTH - PRE - 1)));
    endtask

    task automatic readout_phase(input vec_t v, input bit gaps);
        int step;
        step = (v.pmode == 2) ? 3 : 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    rd_en = 1'b0;
                    tick();
                end
            end
            sb.push_back('{exp_data: pv(v.pmode, v.exp_k + step * (i - PRE)), exp_last: (i == DEPTH - 1)});
            rd_en = 1'b1;
            tick();
        end
        // rd_en held through the retire cycle must be ignored
        tick();
        rd_en = 1'b0;
        check("state_idle_after_read", 32'(state), 32'd0);
        check("triggered_clr", 32'(triggered), 32'd0);
        check("done_clr", 32'(done), 32'd0);
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int k;
        int n;
        rst = 1'b0;
        probe = '0; trig_value = '0; trig_mask = '0; trig_edge = 1'b0;
        arm = 1'b0; arm0 = 1'b0; abort = 1'b0; rd_en = 1'b0; rd_en0 = 1'b0; qual = 1'b1;

        vecs.push_back('{edge_m: 1'b0, mask: 19'h7FFFF, value: 19'h0000A, pmode: 0, exp_k: 10});
        vecs.push_back('{edge_m: 1'b0, mask: 19'h0000F, value: 19'h00003, pmode: 0, exp_k: 19});
        vecs.push_back('{edge_m: 1'b1, mask: 19'h00001, value: 19'h00001, pmode: 0, exp_k: 5});
        vecs.push_back('{edge_m: 1'b1, mask: 19'h00007, value: 19'h00007, pmode: 0, exp_k: 7});
        vecs.push_back('{edge_m: 1'b0, mask: 19'h00000, value: 19'h00000, pmode: 0, exp_k: 4});
        vecs.push_back('{edge_m: 1'b1, mask: 19'h00001, value: 19'h00001, pmode: 1, exp_k: 7});
        vecs.push_back('{edge_m: 1'b0, mask: 19'h00010, value: 19'h00010, pmode: 0, exp_k: 16});
        vecs.push_back('{edge_m: 1'b0, mask: 19'h00003, value: 19'h00002, pmode: 0, exp_k: 6});
        vecs.push_back('{edge_m: 1'b1, mask: 19'h00001, value: 19'h00000, pmode: 0, exp_k: 4});
`ifdef PROBE_CAPTURE_QUAL_EN
        vecs.push_back('{edge_m: 1'b0, mask: 19'h7FFF0, value: 19'h00010, pmode: 2, exp_k: 18});
`endif

        tick();
        tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b1;
        tick();

        for (int v = 0; v < vecs.size(); v++) begin
            capture_phase(vecs[v]);
            readout_phase(vecs[v], (v % 2) == 1);
        end
        qual = 1'b1;

        // abort in POST, rd_en in IDLE, arm+abort together, then re-arm
        trig_edge = 1'b0; trig_mask = 19'h7FFFF; trig_value = 19'h0000A;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && !triggered; c++) begin
            probe = DW'(k);
            tick();
            k++;
        end
        check("abort_pre_triggered", 32'(triggered), 32'd1);
        for (int c = 0; c < 3; c++) begin
            probe = DW'(k);
            tick();
            k++;
        end
        check("abort_pre_state_post", 32'(state), 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", 32'(state), 32'd0);
        check("abort_triggered", 32'(triggered), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rd_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rd_valid_in_idle", 32'(rd_valid), 32'd0);
        end
        rd_en = 1'b0;
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check("arm_abort_idle", 32'(state), 32'd0);
        tick();
        check("arm_abort_idle2", 32'(state), 32'd0);
        capture_phase(vecs[0]);
        readout_phase(vecs[0], 1'b0);

        // asynchronous reset in the middle of readout
        capture_phase(vecs[1]);
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{exp_data: pv(0, vecs[1].exp_k - PRE + i), exp_last: 1'b0});
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        check("pre_rst_rd_valid", 32'(rd_valid), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_triggered", 32'(triggered), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_rd_last", 32'(rd_last), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        capture_phase(vecs[2]);
        readout_phase(vecs[2], 1'b0);

        // PRE_TRIG=0 instance, mask 0: FILL skipped, hit on first WAIT_TRIG cycle
        trig_edge = 1'b0; trig_mask = '0; trig_value = 19'h12345;
        arm0 = 1'b1;
        tick();
        arm0 = 1'b0;
        check("p0_state_wait", 32'(state0), 32'd2);
        k = 0;
        probe = DW'(k);
        tick();
        check("p0_triggered", 32'(triggered0), 32'd1);
        check("p0_state_post", 32'(state0), 32'd3);
        n = 0;
        while (!done0 && n < 40) begin
            k++;
            probe = DW'(k);
            tick();
            n++;
        end
        check("p0_post_len", 32'(n), 32'd15);
        for (int i = 0; i < DEPTH; i++) begin
            rd_en0 = 1'b1;
            tick();
            check("p0_rd_valid", 32'(rd_valid0), 32'd1);
            check("p0_rd_data", 32'(rd_data0), 32'(i));
            check("p0_rd_last", 32'(rd_last0), 32'(i == DEPTH - 1));
        end
        rd_en0 = 1'b0;
        tick();
        check("p0_state_idle", 32'(state0), 32'd0);
        check("p0_triggered_clr", 32'(triggered0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/probe_capture.md
Name: probe_capture

Overview:
- Parametrised on-chip capture core; successor to the fixed vendor analyzer instance that probes the traffic-light/ESP32 signals (semaforos, ciclo_esp32, dest_esp32, rst).
- Stores a window of DEPTH samples of a DATA_W-bit probe bus around a programmable mask/value trigger.
- Supports level or edge trigger and a configurable pre-trigger depth.
- Results are read back oldest-first through a simple read handshake, for a UART/SPI debug bridge or the ESP32 link.

Parameters:
- DATA_W, 19: probe bus width.
- DEPTH, 256: capture buffer depth; power of 2, at least 4.
- PRE_TRIG, 64: samples kept before the trigger sample; 0 to DEPTH-1.

Ports:
- clk  in  1  capture and readout clock.
- rst  in  1  asynchronous reset, active low.
- probe  in  DATA_W  signals under observation.
- arm  in  1  start-capture pulse; honoured only in IDLE.
- abort  in  1  return to IDLE from any state.
- trig_value  in  DATA_W  trigger compare value.
- trig_mask  in  DATA_W  1 = bit participates in compare.
- trig_edge  in  1  0 = level trigger, 1 = rising-match trigger.
- qual  in  1  storage qualifier; used only with the optional feature.
- state  out  3  0 IDLE, 1 FILL, 2 WAIT_TRIG, 3 POST, 4 DONE.
- triggered  out  1  high from the trigger cycle until return to IDLE.
- done  out  1  high in DONE.
- rd_en  in  1  read request, one sample per pulse-cycle.
- rd_data  out  DATA_W  read sample.
- rd_valid  out  1  rd_data valid, one cycle after an accepted rd_en.
- rd_last  out  1  with rd_valid on the DEPTH-th sample.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; triggered, done, rd_valid, rd_last = 0; rd_data = 0; pointers, counters and match_d = 0. Buffer contents are undefined after reset.
- Match: match = ((probe ^ trig_value) & trig_mask) == 0.
- match_d is a register holding the previous cycle's match, updated every cycle in all states.
- Trigger hit:
  - Level mode: hit = match.
  - Edge mode: hit = match & ~match_d.
  - trig_mask = 0 in level mode: hit on the first WAIT_TRIG cycle.
- Write rule: in FILL, WAIT_TRIG and POST, probe is written to buffer[wr_ptr] every cycle and wr_ptr increments modulo DEPTH.
- IDLE: arm=1 → FILL next cycle; wr_ptr and counters are cleared. If PRE_TRIG = 0, go to WAIT_TRIG directly.
- FILL: stores exactly PRE_TRIG samples, then WAIT_TRIG. Hits during FILL are ignored.
- WAIT_TRIG: keeps writing; the buffer wraps freely. On a hit:
  - the hit sample is written;
  - trig_addr is latched as that sample's address;
  - triggered=1;
  - state → POST.
- POST: stores DEPTH-PRE_TRIG-1 further samples, then DONE.
  - If DEPTH-PRE_TRIG-1 = 0, go from WAIT_TRIG to DONE directly.
  - Final window: PRE_TRIG samples, then the trigger sample, then DEPTH-PRE_TRIG-1 samples.
- DONE entry: rd_ptr = (trig_addr - PRE_TRIG) mod DEPTH.
- DONE readout:
  - rd_en=1 reads buffer[rd_ptr] (synchronous RAM); rd_valid=1 and rd_data are presented the next cycle; rd_ptr increments modulo DEPTH.
  - After DEPTH reads, rd_last=1 accompanies the final rd_valid. The following cycle state → IDLE, and triggered and done → 0.
  - rd_en during that final transition cycle is ignored.
- rd_en outside DONE: ignored; rd_valid stays 0.
- arm outside IDLE: ignored.
- abort=1 in any state → IDLE next cycle.
  - Has priority over arm, hit and rd_en.
  - Clears triggered, done, rd_valid, rd_last.
  - Buffer contents are not cleared.
- Simultaneous arm and abort in IDLE: stay in IDLE.
- Probe inputs are sampled directly on clk; they must be synchronous to clk.
- No latency is added to the probe path beyond the write register.

Optional Feature:
- Macro: PROBE_CAPTURE_QUAL_EN.
- With the macro defined:
  - In FILL, WAIT_TRIG and POST, a sample is written, and counters and wr_ptr advance, only on cycles with qual=1.
  - Hit evaluation is also gated by qual: a hit counts only when qual=1.
  - match_d updates only on qual=1 cycles.
  - Result: sparse events are captured with full depth.
- Without the macro: qual is ignored; every cycle is stored and evaluated as above.

Test Plan:
- DEPTH=16, PRE_TRIG=4, level mode, mask=all ones, value=0x0000A:
  - Stimulus: arm, then probe counts 0,1,2… per cycle.
  - Required response: trigger at sample 10; readout returns 6..21 in order; rd_last on 21; state returns to 0.
- Edge mode, mask=0x00001, value=0x00001:
  - Stimulus: probe bit0 held high through FILL, low 3 cycles, then high.
  - Required response: the hit is the first rising sample after WAIT_TRIG entry; readout index PRE_TRIG holds that sample.
- PRE_TRIG=0, level mode, mask=0:
  - Stimulus: arm.
  - Required response: FILL is skipped; hit on the first WAIT_TRIG cycle; DONE after DEPTH-1 further cycles; the first read is the trigger sample.
- Abort checks:
  - abort during POST → state 0 next cycle; triggered=0.
  - A later arm restarts capture correctly.
  - rd_en in IDLE gives no rd_valid.
- Reset mid-readout:
  - Stimulus: rst=0 after 5 reads.
  - Required response: all outputs 0 immediately (asynchronous).
  - arm after release gives a fresh capture with correct ordering.
- PROBE_CAPTURE_QUAL_EN:
  - Stimulus: qual high every 3rd cycle.
  - Required response: the buffer holds only qualified samples in order; the trigger value on an unqualified cycle is not taken.
